// File: rtl/ifu_pc_pkg.sv
// Shared definitions for the ifu_pc program-counter stage: next-PC op encodings,
// default address map and the helper that decides whether an op redirects fetch.
package ifu_pc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JREG   = 3'd3
    } npc_op_e;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int unsigned IM_WORDS_DEF = 4096;

    // Encodings 4-7 fall through to the sequential path and never redirect.
    function automatic logic is_redirect(input logic [2:0] op, input logic br_cond);
        logic taken;
        taken = 1'b0;
        case (op)
            NPC_BRANCH:         taken = br_cond;
            NPC_JUMP, NPC_JREG: taken = 1'b1;
            default:            taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ifu_pc_if.sv
// Control/status bundle between the decode side and the ifu_pc stage.
// The master drives the next-PC controls; the slave (ifu_pc) returns the fetch address and status.
interface ifu_pc_if;

    logic        en;
    logic [2:0]  npc_op;
    logic        br_cond;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] ra_val;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus8;
    logic        addr_err;
    logic [31:0] fetch_count;

    modport master (
        output en, npc_op, br_cond, imm16, imm26, ra_val,
        input  pc, pc_plus4, pc_plus8, addr_err, fetch_count
    );

    modport slave (
        input  en, npc_op, br_cond, imm16, imm26, ra_val,
        output pc, pc_plus4, pc_plus8, addr_err, fetch_count
    );

endinterface

// File: rtl/ifu_pc_npc_calc.sv
// Combinational next-PC target select and legality check against the
// instruction-memory window [RESET_PC, RESET_PC + 4*IM_WORDS).
module npc_calc
    import ifu_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic [31:0] pc,
    input  logic [2:0]  npc_op,
    input  logic        br_cond,
    input  logic [15:0] imm16,
    input  logic [25:0] imm26,
    input  logic [31:0] ra_val,
    output logic [31:0] target,
    output logic        illegal
);

    // One extra bit so a window ending exactly at 2^32 does not wrap to zero.
    localparam logic [32:0] PC_LIMIT = {1'b0, RESET_PC} + 33'(4 * IM_WORDS);

    logic [31:0] seq;
    logic [31:0] br_off;

    assign seq    = pc + 32'd4;
    assign br_off = {{14{imm16[15]}}, imm16, 2'b00};

    // NOTE: give every always_comb output a default first so no path can infer a latch.
    always_comb begin
        target = seq;
        case (npc_op)
            NPC_BRANCH: if (br_cond) target = seq + br_off;
            NPC_JUMP:   target = {seq[31:28], imm26, 2'b00};
            NPC_JREG:   target = ra_val;
            default:    target = seq;
        endcase
    end

    assign illegal = (target[1:0] != 2'b00)
                   || (target < RESET_PC)
                   || ({1'b0, target} >= PC_LIMIT);

endmodule

// File: rtl/ifu_pc.sv
// Program-counter stage feeding instruction memory: holds pc, the sticky addr_err
// halt flag and the fetch counter. Define DELAY_SLOT_EN for a MIPS branch delay slot.
module ifu_pc
    import ifu_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
    input  logic   clk,
    input  logic   reset,
    ifu_pc_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] target;
    logic        illegal;

    npc_calc #(
        .RESET_PC (RESET_PC),
        .IM_WORDS (IM_WORDS)
    ) u_npc_calc (
        .pc      (pc_q),
        .npc_op  (bus.npc_op),
        .br_cond (bus.br_cond),
        .imm16   (bus.imm16),
        .imm26   (bus.imm26),
        .ra_val  (bus.ra_val),
        .target  (target),
        .illegal (illegal)
    );

`ifdef DELAY_SLOT_EN
    logic        pending_valid_q, pending_valid_d;
    logic [31:0] pending_target_q, pending_target_d;

    // The edge after a taken redirect ignores the presented op and lands on the queued target.
    always_comb begin
        pc_d             = pc_q;
        addr_err_d       = addr_err_q;
        fetch_count_d    = fetch_count_q;
        pending_valid_d  = pending_valid_q;
        pending_target_d = pending_target_q;
        if (bus.en && !addr_err_q) begin
            if (pending_valid_q) begin
                pc_d            = pending_target_q;
                pending_valid_d = 1'b0;
                fetch_count_d   = fetch_count_q + 32'd1;
            end else if (illegal) begin
                addr_err_d = 1'b1;
            end else if (is_redirect(bus.npc_op, bus.br_cond)) begin
                pc_d             = pc_q + 32'd4;
                pending_target_d = target;
                pending_valid_d  = 1'b1;
                fetch_count_d    = fetch_count_q + 32'd1;
            end else begin
                pc_d          = target;
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_valid_q  <= 1'b0;
            pending_target_q <= 32'd0;
        end else begin
            pending_valid_q  <= pending_valid_d;
            pending_target_q <= pending_target_d;
        end
    end
`else
    always_comb begin
        pc_d          = pc_q;
        addr_err_d    = addr_err_q;
        fetch_count_d = fetch_count_q;
        if (bus.en && !addr_err_q) begin
            if (illegal) begin
                addr_err_d = 1'b1;
            end else begin
                pc_d          = target;
                fetch_count_d = fetch_count_q + 32'd1;
            end
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            addr_err_q    <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            addr_err_q    <= addr_err_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus4    = pc_q + 32'd4;
    assign bus.pc_plus8    = pc_q + 32'd8;
    assign bus.addr_err    = addr_err_q;
    assign bus.fetch_count = fetch_count_q;

endmodule
